// File: rtl/ddr3_pkg.sv
// Shared DDR3 command encoding and words-per-command helpers (host and controller side).
package ddr3_pkg;

    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_SCR  = 3'd1;
    localparam logic [2:0] CMD_SCW  = 3'd2;
    localparam logic [2:0] CMD_BLR  = 3'd3;
    localparam logic [2:0] CMD_BLW  = 3'd4;
    localparam logic [2:0] CMD_ATR  = 3'd5;
    localparam logic [2:0] CMD_ATW  = 3'd6;

    // Data words a command consumes from the write path; BLW carries (sz+1)*8.
    function automatic logic [5:0] cmd_words(input logic [2:0] cmd, input logic [1:0] sz);
        case (cmd)
            CMD_SCW, CMD_ATW, CMD_ATR: return 6'd1;
            CMD_BLW:                   return ({4'd0, sz} + 6'd1) << 3;
            default:                   return 6'd0;
        endcase
    endfunction

    function automatic logic cmd_illegal(input logic [2:0] cmd);
        return (cmd == 3'd0) || (cmd == 3'd7);
    endfunction

endpackage

// File: rtl/ddr3_host_sequencer_if.sv
// Host-facing request / write-data / read-response bundle of the sequencer.
interface ddr3_host_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [25:0] req_addr;
    logic [1:0]  req_sz;
    logic [2:0]  req_op;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [25:0] rsp_addr;
    logic        err_cmd;

    modport master (
        output req_valid, req_cmd, req_addr, req_sz, req_op, wr_valid, wr_data, rsp_ready,
        input  req_ready, wr_ready, rsp_valid, rsp_data, rsp_addr, err_cmd
    );
    modport slave (
        input  req_valid, req_cmd, req_addr, req_sz, req_op, wr_valid, wr_data, rsp_ready,
        output req_ready, wr_ready, rsp_valid, rsp_data, rsp_addr, err_cmd
    );
endinterface

// File: rtl/ddr3_host_sequencer_fifo.sv
// Generic synchronous FIFO with show-ahead head; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module FIFO #(
    parameter int DEPTH_P2 = 5,
    parameter int WIDTH    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    din,
    input  logic                push,
    input  logic                pop,
    output logic [WIDTH-1:0]    dout,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_P2:0]   fillcount
);
    localparam int DEPTH = 1 << DEPTH_P2;
    localparam int CW    = DEPTH_P2 + 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_P2-1:0] rd_ptr, wr_ptr;
    logic                do_push, do_pop;

    assign full    = (fillcount == CW'(DEPTH));
    assign empty   = (fillcount == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fillcount <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            fillcount <= fillcount + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ddr3_host_sequencer.sv
// Host request sequencer: stages write data, issues commands with gap-free block
// write bursts, and drains the controller return FIFO into a 2-entry skid buffer.
module ddr3_host_sequencer
    import ddr3_pkg::*;
#(
    parameter int WDEPTH_P2  = 5,
    parameter int CTRL_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    ddr3_host_sequencer_if.slave  host,
    output logic [2:0]            ctrl_cmd,
    output logic [25:0]           ctrl_addr,
    output logic [1:0]            ctrl_sz,
    output logic [2:0]            ctrl_op,
    output logic [15:0]           ctrl_din,
    input  logic                  ctrl_ready,
    input  logic                  ctrl_notfull,
    input  logic [5:0]            ctrl_fillcount,
    output logic                  ctrl_read,
    input  logic [15:0]           ctrl_dout,
    input  logic [25:0]           ctrl_raddr,
    input  logic                  ctrl_validout
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]           state;
    logic [4:0]           burst_cnt;
    logic [WDEPTH_P2:0]   stage_cnt;
    logic [15:0]          stage_head;
    logic                 stage_full, stage_empty;
    logic                 pop, push, accept, illegal, adm_ok;
    logic [5:0]           need, w_cur;

    FIFO #(.DEPTH_P2(WDEPTH_P2), .WIDTH(16)) u_stage (
        .clk(clk), .reset(reset), .din(host.wr_data), .push(push), .pop(pop),
        .dout(stage_head), .full(stage_full), .empty(stage_empty), .fillcount(stage_cnt)
    );

    // Admission, staging pop and data-out steering; ATR also consumes its operand word.
    always_comb begin
        illegal        = cmd_illegal(host.req_cmd);
        need           = cmd_words(host.req_cmd, host.req_sz);
        w_cur          = cmd_words(ctrl_cmd, ctrl_sz);
        adm_ok         = ctrl_ready && ctrl_notfull
                         && (int'(stage_cnt) >= int'(need))
                         && ((CTRL_DEPTH - int'(ctrl_fillcount)) >= int'(need));
        host.req_ready = !reset && (state == S_IDLE) && (illegal || adm_ok);
        accept         = host.req_valid && host.req_ready;
        pop            = !reset && !stage_empty
                         && (((state == S_ISSUE) && (w_cur != 6'd0)) || (state == S_BURST));
        ctrl_din       = pop ? stage_head : 16'd0;
        host.wr_ready  = !stage_full || pop;
        push           = host.wr_valid && host.wr_ready;
    end

    // Command FSM: register on accept, one ISSUE cycle, optional burst, one GAP cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            burst_cnt    <= '0;
            ctrl_cmd     <= '0;
            ctrl_addr    <= '0;
            ctrl_sz      <= '0;
            ctrl_op      <= '0;
            host.err_cmd <= 1'b0;
        end else begin
            host.err_cmd <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    if (illegal) begin
                        host.err_cmd <= 1'b1;
                        state        <= S_GAP;
                    end else begin
                        ctrl_cmd  <= host.req_cmd;
                        ctrl_addr <= host.req_addr;
                        ctrl_sz   <= host.req_sz;
                        ctrl_op   <= host.req_op;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ctrl_cmd <= CMD_IDLE;
                    if (ctrl_cmd == CMD_BLW) begin
                        burst_cnt <= 5'(w_cur - 6'd2);
                        state     <= S_BURST;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_BURST: begin
                    if (burst_cnt == 5'd0) state <= S_GAP;
                    else                   burst_cnt <= burst_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Return path: skid buffer storage and pointers.
    logic        read_q, sk_pop;
    logic [1:0]  sk_cnt;
    logic        sk_wp, sk_rp;
    logic [15:0] sk_data [2];
    logic [25:0] sk_addr [2];

    // Pop the controller at most every other cycle to absorb validout's one-cycle lag.
    always_comb begin
        ctrl_read      = !reset && ctrl_validout && !read_q && (sk_cnt != 2'd2);
        host.rsp_valid = (sk_cnt != 2'd0);
        sk_pop         = host.rsp_valid && host.rsp_ready;
        host.rsp_data  = sk_data[sk_rp];
        host.rsp_addr  = sk_addr[sk_rp];
    end

    // Skid buffer capture on ctrl_read, release on response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_q <= 1'b0;
            sk_cnt <= '0;
            sk_wp  <= 1'b0;
            sk_rp  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                sk_data[i] <= '0;
                sk_addr[i] <= '0;
            end
        end else begin
            read_q <= ctrl_read;
            if (ctrl_read) begin
                sk_data[sk_wp] <= ctrl_dout;
                sk_addr[sk_wp] <= ctrl_raddr;
                sk_wp          <= ~sk_wp;
            end
            if (sk_pop) sk_rp <= ~sk_rp;
            sk_cnt <= sk_cnt + 2'(ctrl_read) - 2'(sk_pop);
        end
    end
endmodule

// File: tb/tb_ddr3_host_sequencer.sv
// Self-checking bench for ddr3_host_sequencer: randomized requests and return
// traffic checked against a queue-based reference model.
module tb_ddr3_host_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  ctrl_cmd, ctrl_op;
    logic [25:0] ctrl_addr;
    logic [1:0]  ctrl_sz;
    logic [15:0] ctrl_din;
    logic        ctrl_ready = 1'b1, ctrl_notfull = 1'b1;
    logic [5:0]  ctrl_fillcount = '0;
    logic        ctrl_read;
    logic [15:0] ctrl_dout = '0;
    logic [25:0] ctrl_raddr = '0;
    logic        ctrl_validout = 1'b0;

    ddr3_host_sequencer_if host();

    ddr3_host_sequencer #(.WDEPTH_P2(5), .CTRL_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .host(host),
        .ctrl_cmd(ctrl_cmd), .ctrl_addr(ctrl_addr), .ctrl_sz(ctrl_sz), .ctrl_op(ctrl_op),
        .ctrl_din(ctrl_din), .ctrl_ready(ctrl_ready), .ctrl_notfull(ctrl_notfull),
        .ctrl_fillcount(ctrl_fillcount), .ctrl_read(ctrl_read), .ctrl_dout(ctrl_dout),
        .ctrl_raddr(ctrl_raddr), .ctrl_validout(ctrl_validout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int rd_count = 0, rd_viol = 0;
    bit rd_seen = 0, rd_prev = 0, prev_nonempty = 0;
    logic [15:0] stage_q [$];
    logic [41:0] ret_q [$];
    logic [41:0] exp_q [$];
    logic [41:0] got_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference rule: data words each command takes from staging.
    function automatic int words_of(input int cmd, input int sz);
        if (cmd == 4) return 8 * (sz + 1);
        if (cmd == 2 || cmd == 5 || cmd == 6) return 1;
        return 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Controller return-FIFO stub: validout reports last cycle's occupancy.
    always begin
        @(posedge clk);
        #1;
        if (rd_seen && ret_q.size() > 0) void'(ret_q.pop_front());
        ctrl_validout = prev_nonempty;
        prev_nonempty = (ret_q.size() > 0);
        if (ret_q.size() > 0) {ctrl_raddr, ctrl_dout} = ret_q[0];
    end

    // Observe read strobes and response handshakes mid-cycle.
    always @(negedge clk) begin
        rd_seen = ctrl_read;
        if (ctrl_read) rd_count++;
        if (ctrl_read && rd_prev) rd_viol++;
        rd_prev = ctrl_read;
        if (host.rsp_valid && host.rsp_ready) got_q.push_back({host.rsp_addr, host.rsp_data});
    end

    task automatic push_word(input logic [15:0] d);
        int t = 0;
        host.wr_valid = 1'b1;
        host.wr_data  = d;
        @(negedge clk);
        while (!host.wr_ready && t < 100) begin @(negedge clk); t++; end
        if (!host.wr_ready) chk("wr_ready_timeout", host.wr_ready, 1);
        else stage_q.push_back(d);
        cyc();
        host.wr_valid = 1'b0;
    endtask

    task automatic wait_accept(input logic [2:0] cmd, input logic [1:0] sz,
                               input logic [25:0] addr, input logic [2:0] op, output bit ok);
        int t = 0;
        host.req_valid = 1'b1;
        host.req_cmd = cmd; host.req_sz = sz; host.req_addr = addr; host.req_op = op;
        @(negedge clk);
        while (!host.req_ready && t < 200) begin @(negedge clk); t++; end
        ok = host.req_ready;
        if (!ok) chk("req_ready_timeout", host.req_ready, 1);
        cyc();
        host.req_valid = 1'b0;
    endtask

    // Issue one request and check the cycle-by-cycle controller command/data stream.
    task automatic run_req(input logic [2:0] cmd, input logic [1:0] sz,
                           input logic [25:0] addr, input logic [2:0] op);
        bit ok;
        int w;
        logic [15:0] e;
        wait_accept(cmd, sz, addr, op, ok);
        if (!ok) return;
        if (cmd == 0 || cmd == 7) begin
            @(negedge clk);
            chk("err_pulse", host.err_cmd, 1);
            chk("err_no_cmd", ctrl_cmd, 0);
            cyc();
            @(negedge clk);
            chk("err_once", host.err_cmd, 0);
            chk("err_no_cmd2", ctrl_cmd, 0);
            cyc();
            return;
        end
        w = words_of(cmd, sz);
        @(negedge clk);
        chk("issue_cmd", ctrl_cmd, cmd);
        chk("issue_addr", ctrl_addr, addr);
        chk("issue_sz", ctrl_sz, sz);
        chk("issue_op", ctrl_op, op);
        e = (w > 0) ? stage_q.pop_front() : 16'd0;
        chk("issue_din", ctrl_din, e);
        for (int i = 1; i < w; i++) begin
            cyc();
            @(negedge clk);
            e = stage_q.pop_front();
            chk("burst_cmd", ctrl_cmd, 0);
            chk("burst_din", ctrl_din, e);
        end
        cyc();
        @(negedge clk);
        chk("gap_cmd", ctrl_cmd, 0);
        chk("gap_din", ctrl_din, 0);
        chk("gap_req_ready", host.req_ready, 0);
        cyc();
    endtask

    task automatic drain_rsp(input int n, input bit rnd);
        int t = 0;
        while (got_q.size() < n && t < 400) begin
            host.rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc();
            t++;
        end
        chk("rsp_count", got_q.size(), n);
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk("rsp_word", got_q.pop_front(), exp_q.pop_front());
        host.rsp_ready = 1'b0;
    endtask

    initial begin
        bit ok;
        int c, s, w;
        logic [41:0] ent;
        host.req_valid = 0; host.req_cmd = 3'd1; host.req_addr = '0; host.req_sz = '0;
        host.req_op = '0; host.wr_valid = 0; host.wr_data = '0; host.rsp_ready = 0;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", host.req_ready, 0);
        chk("rst_cmd", ctrl_cmd, 0);
        chk("rst_din", ctrl_din, 0);
        chk("rst_rsp_valid", host.rsp_valid, 0);
        chk("rst_err", host.err_cmd, 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_wr_ready", host.wr_ready, 1);
        chk("post_rst_req_ready", host.req_ready, 1);
        chk("post_rst_rsp_data", host.rsp_data, 0);
        chk("post_rst_read", ctrl_read, 0);
        cyc();

        // Single write
        push_word(16'hBEEF);
        run_req(3'd2, 2'd0, 26'h0000123, 3'd0);

        // Block write of 16 sequential words
        for (int i = 0; i < 16; i++) push_word(16'(i));
        run_req(3'd4, 2'd1, 26'h0ABCDE0, 3'd3);

        // 32-word block held until staging catches up
        for (int i = 0; i < 20; i++) push_word(16'($urandom));
        host.req_cmd = 3'd4; host.req_sz = 2'd3;
        @(negedge clk);
        chk("blw32_held", host.req_ready, 0);
        cyc();
        for (int i = 0; i < 12; i++) push_word(16'($urandom));
        @(negedge clk);
        chk("blw32_ready", host.req_ready, 1);
        cyc();
        run_req(3'd4, 2'd3, 26'h1000000, 3'd1);

        // Controller fill level and status gating
        for (int i = 0; i < 16; i++) push_word(16'($urandom));
        host.req_cmd = 3'd4; host.req_sz = 2'd1;
        ctrl_fillcount = 6'd20;
        @(negedge clk);
        chk("fill20_held", host.req_ready, 0);
        cyc();
        ctrl_fillcount = 6'd16; ctrl_ready = 1'b0;
        @(negedge clk);
        chk("ctrl_not_ready_held", host.req_ready, 0);
        cyc();
        ctrl_ready = 1'b1; ctrl_notfull = 1'b0;
        @(negedge clk);
        chk("ctrl_full_held", host.req_ready, 0);
        cyc();
        ctrl_notfull = 1'b1;
        @(negedge clk);
        chk("fill16_ready", host.req_ready, 1);
        cyc();
        run_req(3'd4, 2'd1, 26'h0000040, 3'd2);
        ctrl_fillcount = 6'd0;

        // Return path with the response side stalled
        rd_count = 0;
        for (int i = 0; i < 3; i++) begin
            ent = {26'($urandom), 16'($urandom)};
            ret_q.push_back(ent);
            exp_q.push_back(ent);
        end
        repeat (12) cyc();
        chk("stall_reads", rd_count, 2);
        @(negedge clk);
        chk("stall_rsp_valid", host.rsp_valid, 1);
        chk("stall_rsp_head", {host.rsp_addr, host.rsp_data}, exp_q[0]);
        cyc();
        drain_rsp(3, 1'b0);

        // Randomized return traffic with random back-pressure
        for (int i = 0; i < 8; i++) begin
            ent = {26'($urandom), 16'($urandom)};
            ret_q.push_back(ent);
            exp_q.push_back(ent);
        end
        drain_rsp(8, 1'b1);

        // Randomized request mix
        for (int k = 0; k < 25; k++) begin
            c = $urandom_range(1, 6);
            s = $urandom_range(0, 3);
            w = words_of(c, s);
            while (stage_q.size() < w) push_word(16'($urandom));
            if (stage_q.size() < 32 && $urandom_range(0, 2) == 0) push_word(16'($urandom));
            ctrl_fillcount = 6'($urandom_range(0, 32 - w));
            run_req(3'(c), 2'(s), 26'($urandom), 3'($urandom));
        end
        ctrl_fillcount = 6'd0;

        // Reset in the middle of a block write
        while (stage_q.size() < 16) push_word(16'($urandom));
        wait_accept(3'd4, 2'd1, 26'h0000200, 3'd0, ok);
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        stage_q.delete();
        host.req_cmd = 3'd2; host.req_sz = 2'd0;
        @(negedge clk);
        chk("midrst_cmd", ctrl_cmd, 0);
        chk("midrst_din", ctrl_din, 0);
        chk("midrst_stage_empty", host.req_ready, 0);
        chk("midrst_wr_ready", host.wr_ready, 1);
        cyc();
        run_req(3'd7, 2'd0, 26'h0, 3'd0);
        run_req(3'd0, 2'd0, 26'h0, 3'd0);

        chk("read_spacing", rd_viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

endmodule
